// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the unified memory-port arbiter.
// Pure declarations; no logic, no latency.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_MA = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_e;

  localparam int unsigned ARB_STARVE_MAX_DEF  = 4;
  localparam int unsigned ARB_TIMEOUT_CYC_DEF = 255;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the shared memory port: data wins unless fetch has starved.
// Grants are combinational from the requests; the starve counter updates on a grant.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX_DEF
) (
  input  logic iw_clk,
  input  logic iw_rst_n,
  input  logic iw_en,
  input  logic iw_if_req,
  input  logic iw_ma_req,
  output logic ow_gnt_if,
  output logic ow_gnt_ma
);

  localparam int unsigned SW = cnt_w(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  logic          starved;

  always_comb begin
    starved   = (starve_q == SW'(STARVE_MAX));
    ow_gnt_if = iw_en & iw_if_req & (~iw_ma_req | starved);
    ow_gnt_ma = iw_en & iw_ma_req & ~ow_gnt_if;
    starve_d  = starve_q;
    if (ow_gnt_if) begin
      starve_d = '0;
    end else if (ow_gnt_ma) begin
      // Only data grants that overtake a waiting fetch count toward starvation.
      if (!iw_if_req) begin
        starve_d = '0;
      end else if (!starved) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data access, one transaction in flight.
// Request->mem_req 1 cycle, ready->ack 1 cycle; others stall until their own ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned STARVE_MAX  = ARB_STARVE_MAX_DEF,
  parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC_DEF
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_if_req,
  input  logic [ADDR_W-1:0] iw_if_addr,
  output logic              ow_if_ack,
  output logic [DATA_W-1:0] ow_if_rdata,
  input  logic              iw_ma_req,
  input  logic              iw_ma_we,
  input  logic [ADDR_W-1:0] iw_ma_addr,
  input  logic [DATA_W-1:0] iw_ma_wdata,
  output logic              ow_ma_ack,
  output logic [DATA_W-1:0] ow_ma_rdata,
  output logic              ow_mem_req,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  input  logic              iw_mem_ready,
  input  logic [DATA_W-1:0] iw_mem_rdata,
  output logic              ow_if_stall,
  output logic              ow_ma_stall,
  output logic              ow_timeout
);

  localparam int unsigned TO_W = cnt_w(TIMEOUT_CYC);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              ma_ack_q, ma_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ma_rdata_q, ma_rdata_d;
  logic              timeout_q, timeout_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic arb_en;
  logic gnt_if, gnt_ma;
  logic to_hit;

  assign arb_en = (state_q == ARB_IDLE);
  // Current BUSY cycle is the TIMEOUT_CYC-th one without a ready.
  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .iw_clk    (iw_clk),
    .iw_rst_n  (iw_rst_n),
    .iw_en     (arb_en),
    .iw_if_req (iw_if_req),
    .iw_ma_req (iw_ma_req),
    .ow_gnt_if (gnt_if),
    .ow_gnt_ma (gnt_ma)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    ma_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ma_rdata_d  = ma_rdata_q;
    timeout_d   = timeout_q;
    to_cnt_d    = to_cnt_q;

    case (state_q)
      ARB_IDLE: begin
        if (gnt_if) begin
          state_d     = ARB_BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = iw_if_addr;
          mem_wdata_d = '0;
        end else if (gnt_ma) begin
          state_d     = ARB_BUSY_MA;
          mem_req_d   = 1'b1;
          mem_we_d    = iw_ma_we;
          mem_addr_d  = iw_ma_addr;
          mem_wdata_d = iw_ma_wdata;
        end
      end

      ARB_BUSY_IF, ARB_BUSY_MA: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (iw_mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = ARB_RESP;
          if (state_q == ARB_BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = iw_mem_rdata;
          end else begin
            ma_ack_d = 1'b1;
            if (!mem_we_q) begin
              ma_rdata_d = iw_mem_rdata;
            end
          end
        end else if (to_hit) begin
          // Abort: complete the requester with zero data so the pipeline moves on.
          mem_req_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = ARB_RESP;
          if (state_q == ARB_BUSY_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            ma_ack_d   = 1'b1;
            ma_rdata_d = '0;
          end
        end
      end

      ARB_RESP: begin
        state_d  = ARB_IDLE;
        to_cnt_d = '0;
      end

      default: begin
        state_d  = ARB_IDLE;
        to_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      ma_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ma_rdata_q  <= '0;
      timeout_q   <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      ma_ack_q    <= ma_ack_d;
      if_rdata_q  <= if_rdata_d;
      ma_rdata_q  <= ma_rdata_d;
      timeout_q   <= timeout_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign ow_mem_req   = mem_req_q;
  assign ow_mem_we    = mem_we_q;
  assign ow_mem_addr  = mem_addr_q;
  assign ow_mem_wdata = mem_wdata_q;
  assign ow_if_ack    = if_ack_q;
  assign ow_ma_ack    = ma_ack_q;
  assign ow_if_rdata  = if_rdata_q;
  assign ow_ma_rdata  = ma_rdata_q;
  assign ow_timeout   = timeout_q;

  assign ow_if_stall  = iw_if_req & ~if_ack_q;
  assign ow_ma_stall  = iw_ma_req & ~ma_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected grants and
// read data; a negedge monitor pops and compares whenever the DUT grants or acks.
module tb_mem_port_arbiter;

  localparam int NEVER = 255;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [23:0] wdata;
  } grant_t;

  typedef struct {
    int          lat;
    logic [23:0] rdata;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [23:0] if_addr = '0;
  logic        ma_req = 1'b0;
  logic        ma_we = 1'b0;
  logic [23:0] ma_addr = '0;
  logic [23:0] ma_wdata = '0;
  logic        mem_ready;
  logic [23:0] mem_rdata;

  logic        ow_if_ack, ow_ma_ack, ow_mem_req, ow_mem_we;
  logic        ow_if_stall, ow_ma_stall, ow_timeout;
  logic [23:0] ow_if_rdata, ow_ma_rdata, ow_mem_addr, ow_mem_wdata;

  mem_port_arbiter #(
    .ADDR_W      (24),
    .DATA_W      (24),
    .STARVE_MAX  (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .iw_clk       (clk),
    .iw_rst_n     (rst_n),
    .iw_if_req    (if_req),
    .iw_if_addr   (if_addr),
    .ow_if_ack    (ow_if_ack),
    .ow_if_rdata  (ow_if_rdata),
    .iw_ma_req    (ma_req),
    .iw_ma_we     (ma_we),
    .iw_ma_addr   (ma_addr),
    .iw_ma_wdata  (ma_wdata),
    .ow_ma_ack    (ow_ma_ack),
    .ow_ma_rdata  (ow_ma_rdata),
    .ow_mem_req   (ow_mem_req),
    .ow_mem_we    (ow_mem_we),
    .ow_mem_addr  (ow_mem_addr),
    .ow_mem_wdata (ow_mem_wdata),
    .iw_mem_ready (mem_ready),
    .iw_mem_rdata (mem_rdata),
    .ow_if_stall  (ow_if_stall),
    .ow_ma_stall  (ow_ma_stall),
    .ow_timeout   (ow_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  grant_t      exp_grant_q[$];
  resp_t       mem_q[$];
  logic [23:0] exp_if_q[$];
  logic [23:0] exp_ma_q[$];

  int total = 0;
  int bad = 0;
  int req_rise_cyc = 0;
  int req_len = 0;
  int if_ack_cyc = 0;
  int if_ack_cnt = 0;
  int ma_ack_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_txn(input logic we, input logic [23:0] addr, input logic [23:0] wdata,
                          input int lat, input logic [23:0] mem_data);
    grant_t g;
    resp_t  r;
    g.we = we; g.addr = addr; g.wdata = wdata;
    r.lat = lat; r.rdata = mem_data;
    exp_grant_q.push_back(g);
    mem_q.push_back(r);
  endtask

  task automatic if_txn(input logic [23:0] addr);
    int n = 0;
    if_req = 1'b1;
    if_addr = addr;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ow_if_ack && n < 60);
    if (!ow_if_ack) begin
      total++; bad++;
      $display("FAIL if_ack_wait: no ack for addr 0x%0h within %0d cycles", addr, n);
    end
    if_req = 1'b0;
  endtask

  task automatic ma_txn(input logic we, input logic [23:0] addr, input logic [23:0] wdata);
    int n = 0;
    ma_req = 1'b1;
    ma_we = we;
    ma_addr = addr;
    ma_wdata = wdata;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ow_ma_ack && n < 60);
    if (!ow_ma_ack) begin
      total++; bad++;
      $display("FAIL ma_ack_wait: no ack for addr 0x%0h within %0d cycles", addr, n);
    end
    ma_req = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Memory model: one scripted response per transaction, ready after lat cycles.
  initial begin
    resp_t r;
    int    wn;
    bit    active;
    mem_ready = 1'b0;
    mem_rdata = 24'h5A5A5A;
    active = 1'b0;
    wn = 0;
    r.lat = NEVER;
    r.rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = 24'h5A5A5A;
      if (ow_mem_req) begin
        if (!active) begin
          active = 1'b1;
          if (mem_q.size() > 0) r = mem_q.pop_front();
          else begin r.lat = NEVER; r.rdata = '0; end
          wn = r.lat;
        end
        if (r.lat != NEVER) begin
          if (wn == 0) begin
            mem_ready = 1'b1;
            mem_rdata = r.rdata;
            active = 1'b0;
          end else begin
            wn--;
          end
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  // Monitor: compares grants, held request fields, ack pulses and read data.
  initial begin
    grant_t      cur;
    logic        prev_req, prev_if_ack, prev_ma_ack;
    logic [23:0] e;
    int          run;
    prev_req = 1'b0; prev_if_ack = 1'b0; prev_ma_ack = 1'b0; run = 0;
    cur.we = 1'b0; cur.addr = '0; cur.wdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("if_stall", {31'd0, ow_if_stall}, {31'd0, if_req & ~ow_if_ack});
        check("ma_stall", {31'd0, ow_ma_stall}, {31'd0, ma_req & ~ow_ma_ack});
        if (ow_mem_req && !prev_req) begin
          req_rise_cyc = cyc;
          run = 1;
          if (exp_grant_q.size() == 0) begin
            total++; bad++;
            $display("FAIL grant_unexpected: addr 0x%0h granted with nothing expected", ow_mem_addr);
          end else begin
            cur = exp_grant_q.pop_front();
            check("grant_addr", {8'd0, ow_mem_addr}, {8'd0, cur.addr});
            check("grant_we", {31'd0, ow_mem_we}, {31'd0, cur.we});
            if (cur.we) check("grant_wdata", {8'd0, ow_mem_wdata}, {8'd0, cur.wdata});
          end
        end else if (ow_mem_req) begin
          run++;
          check("hold_addr", {8'd0, ow_mem_addr}, {8'd0, cur.addr});
          check("hold_we", {31'd0, ow_mem_we}, {31'd0, cur.we});
        end else if (prev_req) begin
          req_len = run;
        end
        if (ow_if_ack) begin
          if_ack_cyc = cyc;
          if_ack_cnt++;
          check("if_ack_pulse", {31'd0, prev_if_ack}, 32'd0);
          if (exp_if_q.size() == 0) begin
            total++; bad++;
            $display("FAIL if_ack_unexpected: rdata 0x%0h", ow_if_rdata);
          end else begin
            e = exp_if_q.pop_front();
            check("if_rdata", {8'd0, ow_if_rdata}, {8'd0, e});
          end
        end
        if (ow_ma_ack) begin
          ma_ack_cnt++;
          check("ma_ack_pulse", {31'd0, prev_ma_ack}, 32'd0);
          if (exp_ma_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ma_ack_unexpected: rdata 0x%0h", ow_ma_rdata);
          end else begin
            e = exp_ma_q.pop_front();
            check("ma_rdata", {8'd0, ow_ma_rdata}, {8'd0, e});
          end
        end
      end
      prev_req = ow_mem_req;
      prev_if_ack = ow_if_ack;
      prev_ma_ack = ow_ma_ack;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    int acks;

    // Reset state
    #12;
    check("rst_mem_req", {31'd0, ow_mem_req}, 32'd0);
    check("rst_mem_addr", {8'd0, ow_mem_addr}, 32'd0);
    check("rst_if_ack", {31'd0, ow_if_ack}, 32'd0);
    check("rst_ma_ack", {31'd0, ow_ma_ack}, 32'd0);
    check("rst_timeout", {31'd0, ow_timeout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Lone fetch: mem_req at N+1, ack at N+3
    push_txn(1'b0, 24'h000010, 24'h0, 1, 24'hABCDEF);
    exp_if_q.push_back(24'hABCDEF);
    t0 = cyc;
    if_txn(24'h000010);
    settle();
    check("lone_req_lat", req_rise_cyc - t0, 32'd1);
    check("lone_ack_lat", if_ack_cyc - t0, 32'd3);
    check("lone_no_ma_ack", ma_ack_cnt, 32'd0);

    // Simultaneous requests: data first, then fetch
    push_txn(1'b0, 24'h000100, 24'h0, 1, 24'h111111);
    exp_ma_q.push_back(24'h111111);
    push_txn(1'b0, 24'h000020, 24'h0, 2, 24'h222222);
    exp_if_q.push_back(24'h222222);
    fork
      if_txn(24'h000020);
      begin
        ma_txn(1'b0, 24'h000100, 24'h0);
        check("sim_if_stall_waiting", {31'd0, ow_if_stall}, 32'd1);
      end
    join
    settle();

    // Starvation: 4 data grants, fetch, 4 data grants, fetch, rest data
    for (int i = 0; i < 4; i++) begin
      push_txn(1'b0, 24'(32'h300 + i), 24'h0, 0, 24'(32'hA00000 + i));
    end
    push_txn(1'b0, 24'h000030, 24'h0, 0, 24'hF00030);
    for (int i = 4; i < 8; i++) begin
      push_txn(1'b0, 24'(32'h300 + i), 24'h0, 0, 24'(32'hA00000 + i));
    end
    push_txn(1'b0, 24'h000031, 24'h0, 0, 24'hF00031);
    for (int i = 8; i < 10; i++) begin
      push_txn(1'b0, 24'(32'h300 + i), 24'h0, 0, 24'(32'hA00000 + i));
    end
    for (int i = 0; i < 10; i++) exp_ma_q.push_back(24'(32'hA00000 + i));
    exp_if_q.push_back(24'hF00030);
    exp_if_q.push_back(24'hF00031);
    fork
      begin
        for (int i = 0; i < 10; i++) ma_txn(1'b0, 24'(32'h300 + i), 24'h0);
      end
      begin
        if_txn(24'h000030);
        if_txn(24'h000031);
      end
    join
    settle();

    // Write: rdata keeps the last read value
    push_txn(1'b1, 24'h000200, 24'h123456, 1, 24'h777777);
    exp_ma_q.push_back(24'hA00009);
    ma_txn(1'b1, 24'h000200, 24'h123456);
    settle();
    check("write_no_timeout", {31'd0, ow_timeout}, 32'd0);

    // Memory never ready: abort after 8 BUSY cycles, sticky flag
    push_txn(1'b0, 24'h000040, 24'h0, NEVER, 24'h0);
    exp_if_q.push_back(24'h000000);
    if_txn(24'h000040);
    settle();
    check("to_req_len", req_len, 32'd8);
    check("to_flag_set", {31'd0, ow_timeout}, 32'd1);
    push_txn(1'b0, 24'h000050, 24'h0, 2, 24'h5555AA);
    exp_ma_q.push_back(24'h5555AA);
    ma_txn(1'b0, 24'h000050, 24'h0);
    settle();
    check("to_flag_sticky", {31'd0, ow_timeout}, 32'd1);

    // Reset during BUSY_MA
    push_txn(1'b0, 24'h000500, 24'h0, NEVER, 24'h0);
    ma_req = 1'b1; ma_we = 1'b0; ma_addr = 24'h000500; ma_wdata = 24'h0;
    n = 0;
    while (!ow_mem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rstb_busy_reached", {31'd0, ow_mem_req}, 32'd1);
    acks = ma_ack_cnt;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rstb_mem_req", {31'd0, ow_mem_req}, 32'd0);
    check("rstb_mem_addr", {8'd0, ow_mem_addr}, 32'd0);
    check("rstb_ma_ack", {31'd0, ow_ma_ack}, 32'd0);
    check("rstb_ma_rdata", {8'd0, ow_ma_rdata}, 32'd0);
    check("rstb_if_rdata", {8'd0, ow_if_rdata}, 32'd0);
    check("rstb_timeout", {31'd0, ow_timeout}, 32'd0);
    ma_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstb_no_ack", ma_ack_cnt, acks);
    push_txn(1'b0, 24'h000600, 24'h0, 1, 24'h654321);
    exp_ma_q.push_back(24'h654321);
    ma_txn(1'b0, 24'h000600, 24'h0);
    settle();

    check("grant_q_drained", exp_grant_q.size(), 32'd0);
    check("if_q_drained", exp_if_q.size(), 32'd0);
    check("ma_q_drained", exp_ma_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
